// File: rtl/otter_pkg.sv
// otter_pkg: types shared by the OTTER control unit and the instruction decoder.
//   opcode_t        - RV32I major opcodes (instruction[6:0])
//   funct3_system_t - funct3 values used in the SYSTEM opcode space
//   cu_state_t      - control-unit FSM state encoding
package otter_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_REG    = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    F3_MRET   = 3'b000,
    F3_CSRRW  = 3'b001,
    F3_CSRRS  = 3'b010,
    F3_CSRRC  = 3'b011,
    F3_CSRRWI = 3'b101,
    F3_CSRRSI = 3'b110,
    F3_CSRRCI = 3'b111
  } funct3_system_t;

  typedef enum logic [1:0] {
    ST_FETCH     = 2'b00,
    ST_EXEC      = 2'b01,
    ST_WB        = 2'b10,
    ST_INTERRUPT = 2'b11
  } cu_state_t;

endpackage

// File: rtl/otter_cu_fsm.sv
// otter_cu_fsm: multicycle control unit for the OTTER RV32I core.
// Sequences FETCH -> EXEC -> (WB) -> (INTERRUPT) -> FETCH and produces the
// write/read enables for the datapath as combinational functions of the state.
// Ports:
//   CLK, RST (async, active-high)
//   CU_OPCODE[6:0], CU_FUNC3[2:0] - fields of the fetched instruction
//   INTR      - pending interrupt (already MIE-qualified)
//   MEM_READY - data-memory read data valid
//   PC_WRITE, REG_WRITE, MEM_RDEN1, MEM_RDEN2, MEM_WE2, CSR_WE,
//   INT_TAKEN, MRET_EXEC - control strobes
module otter_cu_fsm
  import otter_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] CU_OPCODE,
  input  logic [2:0] CU_FUNC3,
  input  logic       INTR,
  input  logic       MEM_READY,
  output logic       PC_WRITE,
  output logic       REG_WRITE,
  output logic       MEM_RDEN1,
  output logic       MEM_RDEN2,
  output logic       MEM_WE2,
  output logic       CSR_WE,
  output logic       INT_TAKEN,
  output logic       MRET_EXEC
);

  cu_state_t state_q;
  cu_state_t state_d;
  opcode_t   opcode_s;

  logic pc_write_s;
  logic reg_write_s;
  logic mem_rden1_s;
  logic mem_rden2_s;
  logic mem_we2_s;
  logic csr_we_s;
  logic int_taken_s;
  logic mret_exec_s;

  assign opcode_s = opcode_t'(CU_OPCODE);

  // State register; reset lands in FETCH without waiting for a clock.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control-strobe decode.
  always_comb begin
    state_d     = state_q;
    pc_write_s  = 1'b0;
    reg_write_s = 1'b0;
    mem_rden1_s = 1'b0;
    mem_rden2_s = 1'b0;
    mem_we2_s   = 1'b0;
    csr_we_s    = 1'b0;
    int_taken_s = 1'b0;
    mret_exec_s = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_rden1_s = 1'b1;
        state_d     = ST_EXEC;
      end

      ST_EXEC: begin
        // INTR is sampled here only for non-load instructions; loads defer
        // the decision to the end of WB.
        if (opcode_s == OP_LOAD) begin
          mem_rden2_s = 1'b1;
          state_d     = ST_WB;
        end else begin
          pc_write_s = 1'b1;
          state_d    = INTR ? ST_INTERRUPT : ST_FETCH;
          case (opcode_s)
            OP_STORE: mem_we2_s = 1'b1;
            OP_LUI, OP_AUIPC, OP_REG, OP_IMM, OP_JAL, OP_JALR: reg_write_s = 1'b1;
            OP_SYSTEM: begin
              // mret completes here; any pending INTR is taken next cycle,
              // so MRET_EXEC and INT_TAKEN can never overlap.
              if (CU_FUNC3 == F3_MRET) begin
                mret_exec_s = 1'b1;
              end else begin
                csr_we_s    = 1'b1;
                reg_write_s = 1'b1;
              end
            end
            // BRANCH and unknown opcodes only advance the PC.
            default: ;
          endcase
        end
      end

      ST_WB: begin
        // Wait indefinitely for load data; INTR is ignored while stalled.
        if (MEM_READY) begin
          reg_write_s = 1'b1;
          pc_write_s  = 1'b1;
          state_d     = INTR ? ST_INTERRUPT : ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end

      ST_INTERRUPT: begin
        int_taken_s = 1'b1;
        pc_write_s  = 1'b1;
        state_d     = ST_FETCH;
      end

      default: state_d = ST_FETCH;
    endcase
  end

  // Reset masks every strobe so an abandoned WB/INTERRUPT emits no pulse.
  assign PC_WRITE  = pc_write_s  & ~RST;
  assign REG_WRITE = reg_write_s & ~RST;
  assign MEM_RDEN1 = mem_rden1_s & ~RST;
  assign MEM_RDEN2 = mem_rden2_s & ~RST;
  assign MEM_WE2   = mem_we2_s   & ~RST;
  assign CSR_WE    = csr_we_s    & ~RST;
  assign INT_TAKEN = int_taken_s & ~RST;
  assign MRET_EXEC = mret_exec_s & ~RST;

endmodule

// File: tb/tb_otter_cu_fsm.sv
// tb_otter_cu_fsm: self-checking bench for otter_cu_fsm.
// Each instruction is expanded by a reference model into the list of output
// vectors it should produce, one per cycle, from the control-unit rules.
// Inputs change just after the falling edge and outputs are checked 1 time
// unit later, away from the rising edge.
module tb_otter_cu_fsm;

  logic       CLK;
  logic       RST;
  logic [6:0] CU_OPCODE;
  logic [2:0] CU_FUNC3;
  logic       INTR;
  logic       MEM_READY;
  logic       PC_WRITE, REG_WRITE, MEM_RDEN1, MEM_RDEN2;
  logic       MEM_WE2, CSR_WE, INT_TAKEN, MRET_EXEC;

  int checks;
  int failures;

  // Output vector: {PC_WRITE, REG_WRITE, MEM_RDEN1, MEM_RDEN2, MEM_WE2, CSR_WE, INT_TAKEN, MRET_EXEC}
  localparam logic [7:0] V_PCW  = 8'b1000_0000;
  localparam logic [7:0] V_REGW = 8'b0100_0000;
  localparam logic [7:0] V_RD1  = 8'b0010_0000;
  localparam logic [7:0] V_RD2  = 8'b0001_0000;
  localparam logic [7:0] V_WE2  = 8'b0000_1000;
  localparam logic [7:0] V_CSR  = 8'b0000_0100;
  localparam logic [7:0] V_INT  = 8'b0000_0010;
  localparam logic [7:0] V_MRET = 8'b0000_0001;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] OPI    = 7'b0010011;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OPR    = 7'b0110011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  logic [6:0] op_table [10];

  otter_cu_fsm dut (
    .CLK       (CLK),
    .RST       (RST),
    .CU_OPCODE (CU_OPCODE),
    .CU_FUNC3  (CU_FUNC3),
    .INTR      (INTR),
    .MEM_READY (MEM_READY),
    .PC_WRITE  (PC_WRITE),
    .REG_WRITE (REG_WRITE),
    .MEM_RDEN1 (MEM_RDEN1),
    .MEM_RDEN2 (MEM_RDEN2),
    .MEM_WE2   (MEM_WE2),
    .CSR_WE    (CSR_WE),
    .INT_TAKEN (INT_TAKEN),
    .MRET_EXEC (MRET_EXEC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [7:0] outs();
    return {PC_WRITE, REG_WRITE, MEM_RDEN1, MEM_RDEN2, MEM_WE2, CSR_WE, INT_TAKEN, MRET_EXEC};
  endfunction

  // What the execute cycle of an instruction should drive.
  function automatic logic [7:0] exec_vec(input logic [6:0] op, input logic [2:0] f3);
    if (op == LOAD)                          return V_RD2;
    if (op == STORE)                         return V_WE2 | V_PCW;
    if (op == SYSTEM && f3 == 3'd0)          return V_MRET | V_PCW;
    if (op == SYSTEM)                        return V_CSR | V_REGW | V_PCW;
    if (op inside {LUI, AUIPC, OPR, OPI, JAL, JALR}) return V_REGW | V_PCW;
    return V_PCW;
  endfunction

  // Runs one full instruction starting just after a falling edge with the FSM
  // in FETCH; ends just after the falling edge where the next FETCH begins.
  // nwait = MEM_READY-low cycles in WB; take_int = INTR at the decision cycle.
  // INTR and MEM_READY are randomised in every cycle where they must not matter.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                           input int nwait, input logic take_int, input string name);
    logic [7:0] exp_q [$];
    logic       rdy_q [$];
    logic       int_q [$];
    logic [7:0] got;
    bit         is_load;
    is_load = (op == LOAD);
    exp_q.push_back(V_RD1); rdy_q.push_back(1'($urandom)); int_q.push_back(1'($urandom));
    exp_q.push_back(exec_vec(op, f3)); rdy_q.push_back(1'($urandom));
    int_q.push_back(is_load ? 1'($urandom) : take_int);
    if (is_load) begin
      for (int k = 0; k < nwait; k++) begin
        exp_q.push_back(8'd0); rdy_q.push_back(1'b0); int_q.push_back(1'($urandom));
      end
      exp_q.push_back(V_REGW | V_PCW); rdy_q.push_back(1'b1); int_q.push_back(take_int);
    end
    if (take_int) begin
      exp_q.push_back(V_INT | V_PCW); rdy_q.push_back(1'($urandom)); int_q.push_back(1'($urandom));
    end
    for (int c = 0; c < exp_q.size(); c++) begin
      CU_OPCODE = op;
      CU_FUNC3  = f3;
      MEM_READY = rdy_q[c];
      INTR      = int_q[c];
      #1;
      got = outs();
      checks++;
      if (got !== exp_q[c]) begin
        failures++;
        $display("FAIL %s op=%b f3=%0d cyc%0d: got %b expected %b", name, op, f3, c, got, exp_q[c]);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    #1;
    RST = 1'b1; MEM_READY = 1'b1; INTR = 1'b1;
    #1;
    checks++;
    if (outs() !== 8'd0) begin
      failures++;
      $display("FAIL reset_async: got %b expected %b", outs(), 8'd0);
    end
    @(negedge CLK);
    checks++;
    if (outs() !== 8'd0) begin
      failures++;
      $display("FAIL reset_held: got %b expected %b", outs(), 8'd0);
    end
    RST = 1'b0;
  endtask

  task automatic test_op();
    run_instr(OPR, 3'd0, 0, 1'b0, "op_basic");
  endtask

  task automatic test_load_wait();
    run_instr(LOAD, 3'd2, 3, 1'b0, "load_wait3");
    run_instr(LOAD, 3'd2, 0, 1'b1, "load_nowait_int");
  endtask

  task automatic test_store_intr();
    run_instr(STORE, 3'd2, 0, 1'b1, "store_intr");
  endtask

  task automatic test_mret_intr();
    run_instr(SYSTEM, 3'd0, 0, 1'b1, "mret_intr");
    run_instr(SYSTEM, 3'd1, 0, 1'b0, "csrrw");
  endtask

  task automatic test_nop_opcode();
    run_instr(7'b0000000, 3'd0, 0, 1'b0, "nop_zero");
    run_instr(BRANCH, 3'd1, 0, 1'b0, "branch");
  endtask

  task automatic test_back_to_back();
    run_instr(JAL, 3'd0, 0, 1'b1, "b2b_int_a");
    run_instr(LUI, 3'd0, 0, 1'b1, "b2b_int_b");
    run_instr(LOAD, 3'd0, 2, 1'b1, "b2b_int_c");
  endtask

  task automatic test_reset_mid_wb();
    logic [7:0] got;
    CU_OPCODE = LOAD; CU_FUNC3 = 3'd2; MEM_READY = 1'b0; INTR = 1'b0;
    #1;
    checks++;
    if (outs() !== V_RD1) begin
      failures++; $display("FAIL rstwb_fetch: got %b expected %b", outs(), V_RD1);
    end
    @(negedge CLK); #1;
    checks++;
    if (outs() !== V_RD2) begin
      failures++; $display("FAIL rstwb_exec: got %b expected %b", outs(), V_RD2);
    end
    @(negedge CLK); #1;
    checks++;
    if (outs() !== 8'd0) begin
      failures++; $display("FAIL rstwb_stall: got %b expected %b", outs(), 8'd0);
    end
    // Data becomes ready at the same moment reset hits: nothing may be written.
    MEM_READY = 1'b1; INTR = 1'b1; RST = 1'b1;
    #1;
    got = outs();
    checks++;
    if (got !== 8'd0) begin
      failures++; $display("FAIL rstwb_async: got %b expected %b", got, 8'd0);
    end
    @(posedge CLK); #1;
    checks++;
    if (outs() !== 8'd0) begin
      failures++; $display("FAIL rstwb_hold: got %b expected %b", outs(), 8'd0);
    end
    @(negedge CLK);
    RST = 1'b0;
    run_instr(OPI, 3'd0, 0, 1'b0, "rstwb_release");
  endtask

  task automatic test_random();
    logic [6:0] op;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 4) == 0) op = 7'($urandom);
      else                           op = op_table[$urandom_range(0, 9)];
      run_instr(op, 3'($urandom), $urandom_range(0, 4), ($urandom_range(0, 2) == 0), "random");
    end
  endtask

  initial begin
    op_table = '{LOAD, OPI, AUIPC, STORE, OPR, LUI, BRANCH, JALR, JAL, SYSTEM};
    checks = 0; failures = 0;
    RST = 1'b1; CU_OPCODE = 7'd0; CU_FUNC3 = 3'd0; INTR = 1'b0; MEM_READY = 1'b0;
    @(negedge CLK);
    test_reset();
    test_op();
    test_load_wait();
    test_store_intr();
    test_mret_intr();
    test_nop_opcode();
    test_back_to_back();
    test_reset_mid_wb();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
